// File: rtl/gray_cnt_sched.sv
// Round-robin scheduler sharing one 4-bit gray-code counter between NREQ requesters.
// Optional readback check of the final code is built when GRAY_CNT_SCHED_CHECK_EN is defined.
module gray_cnt_sched #(
  parameter int NREQ = 4
) (
  input  logic              CLK,
  input  logic              CDN,
  input  logic [NREQ-1:0]   REQ,
  input  logic [4*NREQ-1:0] LDV,
  input  logic [4*NREQ-1:0] STEPS,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   DONE,
  output logic              BUSY,
  output logic              ERR,
  output logic              CNT_CD,
  output logic              CNT_LD,
  output logic              CNT_EN,
  output logic [3:0]        CNT_D,
  input  logic [3:0]        CNT_Q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_FIN   = 3'd4
  } state_e;

`ifdef GRAY_CNT_SCHED_CHECK_EN
  localparam state_e S_AFTER = S_CHECK;
`else
  localparam state_e S_AFTER = S_FIN;
`endif

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] x);
    return (x == PW'(NREQ - 1)) ? '0 : x + PW'(1'b1);
  endfunction

  logic [3:0] ldv_a   [NREQ];
  logic [3:0] steps_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign ldv_a[g]   = LDV[4*g+3:4*g];
    assign steps_a[g] = STEPS[4*g+3:4*g];
  end

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, gidx_q, gidx_d, pick_s;
  logic            found_s;
  logic [3:0]      ld_q, ld_d, st_q, st_d, step_q, step_d, cnt_d_q, cnt_d_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            busy_q, busy_d, cnt_cd_q, cnt_cd_d;
  logic            cnt_ld_q, cnt_ld_d, cnt_en_q, cnt_en_d;
`ifdef GRAY_CNT_SCHED_CHECK_EN
  logic [3:0]      exp_q, exp_d;
  logic            err_q, err_d;
`else
  logic            unused_cnt_q;
  assign unused_cnt_q = ^CNT_Q;
`endif

  // Round-robin search: first requester at or after the pointer, wrapping at NREQ.
  always_comb begin
    logic [PW-1:0] cand;
    cand    = ptr_q;
    pick_s  = ptr_q;
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pick_s  = (!found_s && REQ[cand]) ? cand : pick_s;
      found_s = found_s | REQ[cand];
      cand    = ptr_inc(cand);
    end
  end

  // Next-state and next-output logic for the run sequencer.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    ld_d     = ld_q;
    st_d     = st_q;
    step_d   = step_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    cnt_cd_d = 1'b0;
    cnt_ld_d = 1'b0;
    cnt_en_d = 1'b0;
    cnt_d_d  = cnt_d_q;
`ifdef GRAY_CNT_SCHED_CHECK_EN
    exp_d    = exp_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Hold off while the counter is still being cleared after reset.
        if (found_s && !cnt_cd_q) begin
          gidx_d         = pick_s;
          gnt_d          = '0;
          gnt_d[pick_s]  = 1'b1;
          ld_d           = ldv_a[pick_s];
          st_d           = steps_a[pick_s];
          cnt_d_d        = ldv_a[pick_s];
          cnt_ld_d       = 1'b1;
          state_d        = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
`ifdef GRAY_CNT_SCHED_CHECK_EN
        exp_d = bin2gray(gray2bin(ld_q) + st_q);
`endif
        if (!REQ[gidx_q]) begin
          gnt_d   = '0;
          ptr_d   = ptr_inc(gidx_q);
          state_d = S_IDLE;
        end else if (st_q == 4'd0) begin
          state_d = S_AFTER;
        end else begin
          step_d   = st_q;
          cnt_en_d = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (!REQ[gidx_q]) begin
          gnt_d   = '0;
          ptr_d   = ptr_inc(gidx_q);
          state_d = S_IDLE;
        end else if (step_q == 4'd1) begin
          step_d  = 4'd0;
          state_d = S_AFTER;
        end else begin
          step_d   = step_q - 4'd1;
          cnt_en_d = 1'b1;
        end
      end
      S_CHECK: begin
`ifdef GRAY_CNT_SCHED_CHECK_EN
        err_d = err_q | (CNT_Q != exp_q);
`endif
        state_d = S_FIN;
      end
      S_FIN: begin
        done_d  = gnt_q;
        gnt_d   = '0;
        ptr_d   = ptr_inc(gidx_q);
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      ld_q     <= 4'd0;
      st_q     <= 4'd0;
      step_q   <= 4'd0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      cnt_cd_q <= 1'b1;
      cnt_ld_q <= 1'b0;
      cnt_en_q <= 1'b0;
      cnt_d_q  <= 4'd0;
`ifdef GRAY_CNT_SCHED_CHECK_EN
      exp_q    <= 4'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      ld_q     <= ld_d;
      st_q     <= st_d;
      step_q   <= step_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      cnt_cd_q <= cnt_cd_d;
      cnt_ld_q <= cnt_ld_d;
      cnt_en_q <= cnt_en_d;
      cnt_d_q  <= cnt_d_d;
`ifdef GRAY_CNT_SCHED_CHECK_EN
      exp_q    <= exp_d;
      err_q    <= err_d;
`endif
    end
  end

  assign GNT    = gnt_q;
  assign DONE   = done_q;
  assign BUSY   = busy_q;
  assign CNT_CD = cnt_cd_q;
  assign CNT_LD = cnt_ld_q;
  assign CNT_EN = cnt_en_q;
  assign CNT_D  = cnt_d_q;
`ifdef GRAY_CNT_SCHED_CHECK_EN
  assign ERR    = err_q;
`else
  assign ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_gray_cnt_sched.sv
// Bench for gray_cnt_sched: a behavioural gray counter closes the loop, and
// run results are compared against table constants and a lookup-table reference.
module tb_gray_cnt_sched;

  localparam int NREQ = 4;
`ifdef GRAY_CNT_SCHED_CHECK_EN
  localparam int LAT_ADD = 3;
  localparam bit CHK_EN  = 1'b1;
`else
  localparam int LAT_ADD = 2;
  localparam bit CHK_EN  = 1'b0;
`endif

  logic              clk;
  logic              CDN;
  logic [NREQ-1:0]   REQ;
  logic [4*NREQ-1:0] LDV;
  logic [4*NREQ-1:0] STEPS;
  logic [NREQ-1:0]   GNT;
  logic [NREQ-1:0]   DONE;
  logic              BUSY, ERR, CNT_CD, CNT_LD, CNT_EN;
  logic [3:0]        CNT_D;
  logic [3:0]        CNT_Q;

  logic [3:0] cnt_m;
  logic       force0;
  logic [3:0] gtab [16];
  int         total;
  int         bad;
  bit         model_err;

  gray_cnt_sched #(.NREQ(NREQ)) dut (
    .CLK(clk), .CDN(CDN), .REQ(REQ), .LDV(LDV), .STEPS(STEPS),
    .GNT(GNT), .DONE(DONE), .BUSY(BUSY), .ERR(ERR),
    .CNT_CD(CNT_CD), .CNT_LD(CNT_LD), .CNT_EN(CNT_EN), .CNT_D(CNT_D), .CNT_Q(CNT_Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 16; k++) gtab[k] = 4'(k ^ (k >> 1));
  end

  // Position of a gray code in the counting sequence.
  function automatic int gpos(input logic [3:0] g);
    int r;
    r = 0;
    for (int k = 0; k < 16; k++) if (gtab[k] == g) r = k;
    return r;
  endfunction

  function automatic logic [3:0] ref_final(input logic [3:0] ldv, input logic [3:0] st);
    return gtab[(gpos(ldv) + int'(st)) % 16];
  endfunction

  // Behavioural counter macro (async clear, load, enable).
  always @(posedge clk or posedge CNT_CD) begin
    if (CNT_CD) cnt_m <= 4'd0;
    else if (CNT_LD) cnt_m <= CNT_D;
    else if (CNT_EN) cnt_m <= gtab[(gpos(cnt_m) + 1) % 16];
  end
  assign CNT_Q = force0 ? 4'b0000 : cnt_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle invariants: load/enable exclusive, grant and done one-hot or idle.
  always @(negedge clk) begin
    if (CDN) begin
      chk("ld_en_excl", {31'd0, CNT_LD & CNT_EN}, 32'd0);
      chk("gnt_onehot", {31'd0, $onehot0(GNT)}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input int idx, input logic [3:0] ldv, input logic [3:0] st,
                            input logic [3:0] exp_q, input bit frc, input string nm);
    bit got;
    int lat, en_cnt;
    LDV[4*idx +: 4]   = ldv;
    STEPS[4*idx +: 4] = st;
    REQ    = 4'(1 << idx);
    force0 = frc;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      tick();
      got = (GNT != 4'd0);
    end
    chk({nm, "_gnt"}, {28'd0, GNT}, 32'(1 << idx));
    if (!got) begin
      REQ = 4'd0;
      force0 = 1'b0;
      return;
    end
    chk({nm, "_ld"}, {31'd0, CNT_LD}, 32'd1);
    chk({nm, "_d"}, {28'd0, CNT_D}, {28'd0, ldv});
    chk({nm, "_busy"}, {31'd0, BUSY}, 32'd1);
    LDV[4*idx +: 4]   = ~ldv;
    STEPS[4*idx +: 4] = ~st;
    lat = 0;
    en_cnt = 0;
    got = 1'b0;
    for (int w = 0; w < 40 && !got; w++) begin
      tick();
      lat++;
      en_cnt += int'(CNT_EN);
      got = (DONE != 4'd0);
    end
    if (frc && CHK_EN && exp_q != 4'd0) model_err = 1'b1;
    chk({nm, "_lat"}, 32'(lat), 32'(int'(st) + LAT_ADD));
    chk({nm, "_en"}, 32'(en_cnt), {28'd0, st});
    chk({nm, "_done"}, {28'd0, DONE}, 32'(1 << idx));
    chk({nm, "_gclr"}, {28'd0, GNT}, 32'd0);
    if (!frc) chk({nm, "_q"}, {28'd0, CNT_Q}, {28'd0, exp_q});
    chk({nm, "_err"}, {31'd0, ERR}, {31'd0, model_err});
    REQ    = 4'd0;
    force0 = 1'b0;
    tick();
    chk({nm, "_pulse"}, {28'd0, DONE}, 32'd0);
  endtask

  typedef struct {
    int         idx;
    logic [3:0] ldv;
    logic [3:0] steps;
    logic [3:0] exp_q;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int   order [5];
    int   waited;
    bit   got;
    total = 0; bad = 0; model_err = 1'b0;
    force0 = 1'b0;
    REQ = 4'd0; LDV = 16'd0; STEPS = 16'd0;
    vecs[0] = '{0, 4'b0000, 4'd5,  4'b0111};
    vecs[1] = '{1, 4'b1001, 4'd3,  4'b0001};
    vecs[2] = '{2, 4'b0011, 4'd0,  4'b0011};
    vecs[3] = '{0, 4'b0101, 4'd15, 4'b0111};
    vecs[4] = '{1, 4'b0000, 4'd15, 4'b1000};
    vecs[5] = '{3, 4'b1000, 4'd1,  4'b0000};
    order   = '{0, 1, 2, 3, 0};

    CDN = 1'b1;
    #2 CDN = 1'b0;
    tick(); tick();
    chk("rst_cd", {31'd0, CNT_CD}, 32'd1);
    chk("rst_outs", {18'd0, GNT, DONE, BUSY, ERR, CNT_LD, CNT_EN, CNT_D}, 32'd0);
    REQ = 4'b0001;
    CDN = 1'b1;
    tick();
    chk("rel_cd", {31'd0, CNT_CD}, 32'd0);
    chk("rel_nognt", {28'd0, GNT}, 32'd0);
    REQ = 4'd0;
    tick();
    chk("rel_idle", {28'd0, GNT}, 32'd0);

    for (int v = 0; v < 6; v++)
      run_single(vecs[v].idx, vecs[v].ldv, vecs[v].steps, vecs[v].exp_q, 1'b0, $sformatf("vec%0d", v));

    // Contention: all four held, served 0,1,2,3,0 with one idle cycle between.
    LDV = 16'h3210; STEPS = 16'h2222; REQ = 4'hF;
    for (int r = 0; r < 5; r++) begin
      waited = 0; got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        tick(); waited++; got = (GNT != 4'd0);
      end
      chk("rr_gnt", {28'd0, GNT}, 32'(1 << order[r]));
      if (r > 0) begin
        chk("rr_gap", 32'(waited), 32'd1);
        chk("rr_pulse", {28'd0, DONE}, 32'd0);
      end
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        tick(); got = (DONE != 4'd0);
      end
      chk("rr_done", {28'd0, DONE}, 32'(1 << order[r]));
      chk("rr_gclr", {28'd0, GNT}, 32'd0);
      if (r == 4) begin
        REQ = 4'b1100;
        STEPS[11:8] = 4'd5;
      end
    end

    // Abort: requester 2 drops on its second RUN cycle.
    tick();
    chk("ab_gnt", {28'd0, GNT}, 32'b0100);
    tick();
    tick();
    chk("ab_en", {31'd0, CNT_EN}, 32'd1);
    REQ = 4'b1000;
    tick();
    chk("ab_stop", {20'd0, GNT, DONE, 2'd0, BUSY, CNT_EN, CNT_LD}, 32'd0);
    tick();
    chk("ab_next", {28'd0, GNT}, 32'b1000);
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      tick(); got = (DONE != 4'd0);
    end
    chk("ab_done3", {28'd0, DONE}, 32'b1000);
    REQ = 4'd0;
    tick();

    // Forced readback mismatch, then good runs must keep ERR sticky.
    run_single(1, 4'b0011, 4'd1, 4'b0010, 1'b1, "mism");
    run_single(2, 4'b0110, 4'd4, ref_final(4'b0110, 4'd4), 1'b0, "post");

    for (int n = 0; n < 30; n++) begin
      logic [3:0] l, s;
      l = 4'($urandom);
      s = 4'($urandom_range(0, 15));
      run_single(int'($urandom_range(0, 3)), l, s, ref_final(l, s), 1'b0, "rnd");
    end

    CDN = 1'b0;
    #1;
    chk("rst2_err", {31'd0, ERR}, 32'd0);
    chk("rst2_cd", {31'd0, CNT_CD}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/gray_cnt_sched.md
Name: gray_cnt_sched

Overview:
- Round-robin scheduler that shares one 4-bit gray-code up counter (async clear, sync preset, load, enable) between NREQ requesters.
- Each granted requester gets a run: load a start code, advance N gray steps, optional readback check of the final code, then a DONE pulse.
- Sits between requester logic and the counter macro; the counter's Q feeds back into this block.

Parameters:
- NREQ, 4, number of requesters (2..8).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- CDN  in  1  async active-low reset.
- REQ  in  NREQ  per-requester run request; level, held until DONE.
- LDV  in  4*NREQ  per-requester start gray code; slice i = [4i+3:4i].
- STEPS  in  4*NREQ  per-requester step count, 0..15.
- GNT  out  NREQ  one-hot grant; held for the whole run.
- DONE  out  NREQ  one-cycle completion pulse to the granted requester.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- ERR  out  1  sticky readback-mismatch flag.
- CNT_CD  out  1  counter async clear, active high.
- CNT_LD  out  1  counter load strobe.
- CNT_EN  out  1  counter enable.
- CNT_D  out  4  counter load data.
- CNT_Q  in  4  counter output feedback.

Behaviour:
- Reset (CDN low, asynchronous):
  - FSM to IDLE; round-robin pointer to 0; GNT, DONE, CNT_LD, CNT_EN, CNT_D all 0; BUSY=0; ERR=0; CNT_CD=1.
  - CNT_CD deasserts on the first CLK edge after CDN rises. No grant is issued while CNT_CD=1.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, CHECK, FIN.
- IDLE:
  - Pick the first REQ at or after the pointer, wrapping at NREQ.
  - Set GNT[i]. Latch LDV_i into ld_r and STEPS_i into st_r. Go to LOAD.
- LOAD:
  - One cycle with CNT_LD=1 and CNT_D=ld_r.
  - Compute exp = gray(gray2bin(ld_r) + st_r) mod 16.
  - If st_r=0, go to CHECK; else go to RUN with a step counter of st_r.
- RUN:
  - CNT_EN=1 for exactly st_r consecutive cycles; decrement the step counter each cycle.
  - After the last enabled cycle, go to CHECK.
  - Code 1000 wraps to 0000 in the counter; exp accounts for this through the mod-16 add.
- CHECK:
  - One cycle; CNT_Q now reflects the final edge. CNT_LD=0, CNT_EN=0.
  - If CNT_Q != exp, set ERR (sticky; cleared only by reset). Go to FIN.
- FIN:
  - DONE[i]=1 for one cycle; GNT cleared on the same edge.
  - Pointer = i+1 mod NREQ. Go to IDLE.
- Turnaround and latency:
  - Minimum gap between runs is one IDLE cycle.
  - Run latency from grant to DONE is st_r+3 cycles; st_r=0 gives 3.
- Abort:
  - If REQ[i] drops while in LOAD or RUN: CNT_LD and CNT_EN go to 0 next edge, GNT clears, FSM returns to IDLE, no DONE, no check.
  - The pointer still advances. The counter keeps its partial value.
- REQ drop in CHECK or FIN is ignored; the run completes.
- LDV and STEPS changes after grant are ignored (latched values are used).
- Simultaneous requests are served round-robin, so each requester waits at most NREQ-1 runs.
- CNT_LD and CNT_EN are never high in the same cycle.

Optional Feature:
- Macro: GRAY_CNT_SCHED_CHECK_EN.
- Defined: CHECK state and ERR behave as above.
- Undefined:
  - CHECK is skipped; LOAD or the end of RUN goes straight to FIN.
  - ERR is tied to 0 and exp logic is removed.
  - Run latency drops to st_r+2 cycles.

Test Plan:
- Reset release: CDN low→high -> CNT_CD=1 until the first edge after release, then 0; no GNT during CNT_CD=1; all other outputs 0.
- Single run: REQ[0], LDV0=0000, STEPS0=5 -> CNT_LD for 1 cycle with D=0000, CNT_EN for 5 cycles, CNT_Q=0111, ERR=0, DONE[0] 8 cycles after GNT.
- Wrap: LDV=1001, STEPS=3 -> counter passes 1000, 0000 to end at 0001; ERR stays 0.
- Contention: REQ=1111 held continuously -> GNT order 0,1,2,3,0 with one IDLE cycle between runs; each DONE a single-cycle pulse.
- Abort: REQ[2] drops on the 2nd RUN cycle -> CNT_EN low next edge, GNT clears, no DONE[2], next grant goes to requester 3.
- Mismatch: model forces CNT_Q=0000 with LDV=0011, STEPS=1 -> ERR=1 after CHECK and stays high through later good runs until CDN; with the macro undefined, ERR stays 0 and latency is st_r+2.
